// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_ANDN  = 3'd4,
    OP_PASSA = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_skid.sv
// Two-entry skid buffer; in_ready is a registered function of occupancy only.
module logic_unit_skid
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e       state_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic [W-1:0] data0_reg;
  logic [W-1:0] data1_reg;
  logic         in_fire;
  logic         out_fire;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = data0_reg;
  assign in_fire   = in_valid && in_ready_reg;
  assign out_fire  = out_valid_reg && out_ready;

  // data0_reg is always the head entry presented downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      data0_reg     <= '0;
      data1_reg     <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            data0_reg     <= in_data;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            data0_reg <= in_data;
          end else if (in_fire) begin
            data1_reg    <= in_data;
            in_ready_reg <= 1'b0;
            state_reg    <= TWO;
          end else if (out_fire) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            data0_reg    <= data1_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= ONE;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a registered two-entry skid output.
// Optional zero/parity flag outputs are enabled by defining LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic             out_err
);

  logic [WIDTH-1:0] result;
  logic             err;

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (in_op)
      OP_AND:   result = in_a & in_b;
      OP_OR:    result = in_a | in_b;
      OP_XOR:   result = in_a ^ in_b;
      OP_NOR:   result = ~(in_a | in_b);
      OP_ANDN:  result = in_a & ~in_b;
      OP_PASSA: result = in_a;
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int PW = WIDTH + 3;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  assign in_payload = {^result, (result == '0), err, result};
  assign out_parity = out_payload[WIDTH+2];
  assign out_zero   = out_payload[WIDTH+1];
`else
  localparam int PW = WIDTH + 1;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  assign in_payload = {err, result};
`endif

  assign out_err    = out_payload[WIDTH];
  assign out_result = out_payload[WIDTH-1:0];

  logic_unit_skid #(.W(PW)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reset, opcodes, backpressure, streaming, mid-cycle reset.
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_err;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        out_zero;
  logic        out_parity;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero   (out_zero),
    .out_parity (out_parity),
`endif
    .out_err    (out_err)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  task automatic test_reset;
    #12;
    tests_run++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b result=%h err=%b, want 0/00000000/0", out_valid, out_result, out_err);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    $display("[TB] reset: checked");
  endtask

  task automatic test_or_basic;
    out_ready = 1'b1;
    drive(32'h0000_00F0, 32'h0000_000F, 3'd1);
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_00FF || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL or_basic: valid=%b result=%h err=%b, want 1/000000ff/0", out_valid, out_result, out_err);
    end
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL or_drain: out_valid=%b, want 0", out_valid);
    end
    $display("[TB] or_basic: result=%h", 32'h0000_00FF);
  endtask

  task automatic test_ops;
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [2:0]  vop[7];
    logic [31:0] vr [7];
    logic        ve [7];
    va[0] = 32'hFF00_FF00; vb[0] = 32'h0FF0_0FF0; vop[0] = 3'd0; vr[0] = 32'h0F00_0F00; ve[0] = 1'b0;
    va[1] = 32'h1234_5678; vb[1] = 32'hFFFF_FFFF; vop[1] = 3'd2; vr[1] = 32'hEDCB_A987; ve[1] = 1'b0;
    va[2] = 32'hF0F0_F0F0; vb[2] = 32'h0000_FFFF; vop[2] = 3'd3; vr[2] = 32'h0F0F_0000; ve[2] = 1'b0;
    va[3] = 32'hFFFF_0000; vb[3] = 32'h0F0F_0F0F; vop[3] = 3'd4; vr[3] = 32'hF0F0_0000; ve[3] = 1'b0;
    va[4] = 32'hDEAD_BEEF; vb[4] = 32'h1111_1111; vop[4] = 3'd5; vr[4] = 32'hDEAD_BEEF; ve[4] = 1'b0;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vop[5] = 3'd6; vr[5] = 32'h0000_0000; ve[5] = 1'b1;
    va[6] = 32'h1234_5678; vb[6] = 32'h8765_4321; vop[6] = 3'd7; vr[6] = 32'h0000_0000; ve[6] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vop[i]);
      @(negedge clock);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== vr[i] || out_err !== ve[i]) begin
        tests_failed++;
        $display("FAIL op%0d: valid=%b result=%h err=%b, want 1/%h/%b", vop[i], out_valid, out_result, out_err, vr[i], ve[i]);
      end else begin
        $display("[TB] op %0d a=%h b=%h -> %h err=%b", vop[i], va[i], vb[i], out_result, out_err);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(32'hFF00_FF00, 32'h0FF0_0FF0, 3'd0);
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'h0F00_0F00) begin
      tests_failed++;
      $display("FAIL bp_one: valid=%b ready=%b result=%h, want 1/1/0f000f00", out_valid, in_ready, out_result);
    end
    drive(32'h1234_5678, 32'hFFFF_FFFF, 3'd2);
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b0 || out_result !== 32'h0F00_0F00) begin
      tests_failed++;
      $display("FAIL bp_two: ready=%b result=%h, want 0/0f000f00", in_ready, out_result);
    end
    drive(32'hFFFF_0000, 32'h0F0F_0F0F, 3'd4);
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h0F00_0F00) begin
      tests_failed++;
      $display("FAIL bp_hold: ready=%b valid=%b result=%h, want 0/1/0f000f00", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'hEDCB_A987) begin
      tests_failed++;
      $display("FAIL bp_drain2: ready=%b valid=%b result=%h, want 1/1/edcba987", in_ready, out_valid, out_result);
    end
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 32'hF0F0_0000) begin
      tests_failed++;
      $display("FAIL bp_drain3: valid=%b result=%h, want 1/f0f00000", out_valid, out_result);
    end
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%b, want 0", out_valid);
    end
    $display("[TB] backpressure: three results drained in order");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(32'd0, ~32'd0, 3'd2);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_%0d: valid=%b ready=%b result=%h err=%b, want 1/1/ffffffff/0", i, out_valid, in_ready, out_result, out_err);
      end
      if (i < 10) drive(32'(i), ~32'(i), 3'd2);
      else in_valid = 1'b0;
    end
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: valid=%b, want 0", out_valid);
    end
    $display("[TB] back_to_back: 10 XOR results at one per cycle");
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    drive(32'h1111_1111, 32'h2222_2222, 3'd1);
    @(negedge clock);
    drive(32'h4444_4444, 32'h8888_8888, 3'd1);
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mr_fill: ready=%b valid=%b, want 0/1", in_ready, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mr_async: valid=%b result=%h err=%b, want 0/00000000/0", out_valid, out_result, out_err);
    end
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL mr_stale_%0d: valid=%b ready=%b, want 0/1", i, out_valid, in_ready);
      end
    end
    $display("[TB] mid_reset: buffer cleared");
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags;
    out_ready = 1'b1;
    drive(32'hAAAA_AAAA, 32'h5555_5555, 3'd0);
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL flags_and: valid=%b zero=%b parity=%b, want 1/1/0", out_valid, out_zero, out_parity);
    end
    @(negedge clock);
    drive(32'h1, 32'h2, 3'd1);
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL flags_or: valid=%b zero=%b parity=%b, want 1/0/0", out_valid, out_zero, out_parity);
    end
    @(negedge clock);
    drive(32'h7, 32'h0, 3'd5);
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (out_zero !== 1'b0 || out_parity !== 1'b1) begin
      tests_failed++;
      $display("FAIL flags_passa: zero=%b parity=%b, want 0/1", out_zero, out_parity);
    end
    @(negedge clock);
    $display("[TB] flags: checked");
  endtask
`endif

  initial begin
    test_reset();
    test_or_basic();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
